apb_irq_conditioner: RTL and testbench

- Upstream front-end for the event unit.
- Synchronises up to 32 asynchronous interrupt sources into HCLK.
- Per line: applies software-selected polarity, digital glitch filtering, and level or rising-edge detection.
- Drives the event unit's irq_i/event_i inputs; configured over its own APB slave port.

---
 rtl/apb_irq_conditioner_if.sv | 13 +
 rtl/apb_irq_conditioner.sv | 63 ++++++
 tb/tb_apb_irq_conditioner.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_irq_conditioner_if.sv
// apb_irq_conditioner_if: APB slave bus bundle for the interrupt conditioner.
interface apb_irq_conditioner_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0] PWDATA;
  logic PWRITE;
  logic PSEL;
  logic PENABLE;
  logic [31:0] PRDATA;
  logic PREADY;
  logic PSLVERR;
  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
  modport slave (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_irq_conditioner.sv
// apb_irq_conditioner: synchronises, polarity-adjusts, glitch-filters and edge/level-detects interrupt lines.
module apb_irq_conditioner #(
  parameter int NUM_LINES   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  apb_irq_conditioner_if.slave apb,
  input  logic [NUM_LINES-1:0] src_i,
  output logic [NUM_LINES-1:0] irq_o
);
  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_q;
  logic [NUM_LINES-1:0][FILT_W-1:0] cnt_q, cnt_d;
  logic [NUM_LINES-1:0] pol_q, pol_d, edge_q, edge_d, filt_q, filt_d, filt_dly_q, p;
  logic [FILT_W-1:0] thr_q, thr_d;
  logic [2:0] idx;
  logic wr, rd, thr_wr;
  always_comb begin
    idx = apb.PADDR[4:2];
    wr = apb.PSEL & apb.PENABLE & apb.PWRITE;
    rd = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    thr_wr = wr && idx == 3'd2;
    pol_d = wr && idx == 3'd0 ? apb.PWDATA[NUM_LINES-1:0] : pol_q;
    edge_d = wr && idx == 3'd1 ? apb.PWDATA[NUM_LINES-1:0] : edge_q;
    thr_d = thr_wr ? apb.PWDATA[FILT_W-1:0] : thr_q;
    p = sync_q[SYNC_STAGES-1] ^ pol_q;
    filt_d = filt_q;
    cnt_d = '0;
    // a threshold write restarts every count but leaves the filtered levels alone
    for (int i = 0; i < NUM_LINES; i++) begin
      filt_d[i] = !thr_wr && p[i] != filt_q[i] && cnt_q[i] == thr_q ? p[i] : filt_q[i];
      cnt_d[i] = thr_wr || p[i] == filt_q[i] || cnt_q[i] == thr_q ? '0 : cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= '0;
      cnt_q <= '0;
      pol_q <= '0;
      edge_q <= '0;
      thr_q <= '0;
      filt_q <= '0;
      filt_dly_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      cnt_q <= cnt_d;
      pol_q <= pol_d;
      edge_q <= edge_d;
      thr_q <= thr_d;
      filt_q <= filt_d;
      filt_dly_q <= filt_q;
    end
  end
  assign irq_o = filt_q & ~(edge_q & filt_dly_q);
  assign apb.PRDATA = !rd ? '0 :
                      idx == 3'd0 ? 32'(pol_q) :
                      idx == 3'd1 ? 32'(edge_q) :
                      idx == 3'd2 ? 32'(thr_q) :
                      idx == 3'd3 ? 32'(filt_q) : '0;
  assign apb.PREADY = 1'b1;
  assign apb.PSLVERR = 1'b0;
endmodule

// File: tb/tb_apb_irq_conditioner.sv
// tb_apb_irq_conditioner: directed + randomized bench against a sample-history reference model.
module tb_apb_irq_conditioner;
  localparam int N = 32, SYNC = 2, FW = 4;
  logic HCLK = 0, HRESETn = 0;
  logic [N-1:0] src = '0, irq;
  int total = 0, bad = 0;
  apb_irq_conditioner_if #(.APB_ADDR_WIDTH(12)) bus ();
  apb_irq_conditioner #(.NUM_LINES(N), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .apb(bus), .src_i(src), .irq_o(irq));
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: filt takes p once p has disagreed with it on each of the last FILTER+1 edges,
  // provided no threshold write or reset occurred inside that window.
  logic [N-1:0] m_pol, m_edge, m_filt, m_fd;
  logic [FW-1:0] m_thr;
  logic [N-1:0] samp_h [8];
  logic [N-1:0] p_h [16];
  int m_t, m_clr;
  always @(posedge HCLK or negedge HRESETn) begin : model
    int t;
    logic [N-1:0] p, nf;
    logic wr, all;
    logic [2:0] idx;
    if (!HRESETn) begin
      m_pol <= '0; m_edge <= '0; m_filt <= '0; m_fd <= '0; m_thr <= '0;
      m_t <= 0; m_clr <= 0;
      for (int k = 0; k < 8; k++) samp_h[k] <= '0;
      for (int k = 0; k < 16; k++) p_h[k] <= '0;
    end else begin
      t = m_t + 1;
      p = samp_h[SYNC-1] ^ m_pol;
      wr = bus.PSEL & bus.PENABLE & bus.PWRITE;
      idx = bus.PADDR[4:2];
      nf = m_filt;
      if (!(wr && idx == 3'd2) && t - int'(m_thr) > m_clr)
        for (int i = 0; i < N; i++) begin
          all = p[i] != m_filt[i];
          for (int j = 0; j < int'(m_thr); j++) if (p_h[j][i] == m_filt[i]) all = 0;
          if (all) nf[i] = p[i];
        end
      m_filt <= nf;
      m_fd <= m_filt;
      m_t <= t;
      if (wr && idx == 3'd2) begin m_clr <= t; m_thr <= bus.PWDATA[FW-1:0]; end
      if (wr && idx == 3'd0) m_pol <= bus.PWDATA;
      if (wr && idx == 3'd1) m_edge <= bus.PWDATA;
      samp_h[0] <= src;
      for (int k = 1; k < 8; k++) samp_h[k] <= samp_h[k-1];
      p_h[0] <= p;
      for (int k = 1; k < 16; k++) p_h[k] <= p_h[k-1];
    end
  end

  function automatic logic [31:0] m_reg(input logic [2:0] i);
    case (i)
      3'd0: return m_pol;
      3'd1: return m_edge;
      3'd2: return 32'(m_thr);
      3'd3: return m_filt;
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_irq();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_edge[i] ? (m_filt[i] & ~m_fd[i]) : m_filt[i];
    return r;
  endfunction

  always @(posedge HCLK) begin
    #1;
    check("irq_model", irq, exp_irq());
    check("prdata_model", bus.PRDATA,
          (bus.PSEL && bus.PENABLE && !bus.PWRITE) ? m_reg(bus.PADDR[4:2]) : 32'h0);
  end

  task automatic apb_wr(input int idx, input logic [31:0] d);
    @(negedge HCLK);
    bus.PSEL = 1; bus.PWRITE = 1; bus.PENABLE = 0;
    bus.PADDR = 12'(idx * 4) | (12'($urandom) & 12'hFE3); bus.PWDATA = d;
    @(negedge HCLK); bus.PENABLE = 1;
    @(negedge HCLK); bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
  endtask

  task automatic apb_rd(input int idx, output logic [31:0] d);
    @(negedge HCLK);
    bus.PSEL = 1; bus.PWRITE = 0; bus.PENABLE = 0;
    bus.PADDR = 12'(idx * 4) | (12'($urandom) & 12'hFE3);
    @(negedge HCLK); bus.PENABLE = 1;
    #1 d = bus.PRDATA;
    @(negedge HCLK); bus.PSEL = 0; bus.PENABLE = 0;
  endtask

  task automatic wait_lvl(input int line, input logic v, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(posedge HCLK); #1;
      if (irq[line] == v) begin n = k; break; end
    end
  endtask

  task automatic count_hi(input int line, input int cycles, output int c);
    c = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge HCLK); #1;
      if (irq[line]) c++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int n;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1;
    for (int i = 0; i < 4; i++) begin apb_rd(i, d); check($sformatf("reset_reg%0d", i), d, 0); end
    check("reset_irq", irq, 0);
    check("pready", 32'(bus.PREADY), 1);
    check("pslverr", 32'(bus.PSLVERR), 0);
    // level mode, no filtering
    @(negedge HCLK); src[0] = 1;
    wait_lvl(0, 1, 20, n); check("lat0_rise", n, 3);
    apb_rd(3, d); check("status_line0", d, 32'h1);
    @(negedge HCLK); src[0] = 0;
    wait_lvl(0, 0, 20, n); check("lat0_fall", n, 3);
    // glitch rejection with threshold 3
    apb_wr(2, 32'hFFFF_FFF3);
    apb_rd(2, d); check("filter_rd", d, 32'h3);
    @(negedge HCLK); src[5] = 1;
    repeat (3) @(negedge HCLK);
    src[5] = 0;
    count_hi(5, 15, n); check("glitch5", n, 0);
    @(negedge HCLK); src[5] = 1;
    wait_lvl(5, 1, 30, n); check("lat5_rise", n, 6);
    @(negedge HCLK); src[5] = 0;
    wait_lvl(5, 0, 30, n); check("lat5_fall", n, 6);
    // edge mode pulses
    apb_wr(1, 32'hFFFF_FFFF);
    @(negedge HCLK); src[31] = 1;
    count_hi(31, 20, n); check("pulse31_a", n, 1);
    @(negedge HCLK); src[31] = 0;
    repeat (12) @(negedge HCLK);
    src[31] = 1;
    count_hi(31, 20, n); check("pulse31_b", n, 1);
    @(negedge HCLK); src[31] = 0;
    repeat (12) @(negedge HCLK);
    // polarity flip produces one pulse
    apb_wr(2, 0);
    apb_wr(0, 32'h0000_0100);
    count_hi(8, 15, n); check("pol_pulse8", n, 1);
    apb_rd(3, d); check("status_pol", d, 32'h100);
    apb_wr(0, 0);
    apb_wr(1, 0);
    repeat (6) @(negedge HCLK);
    // threshold write mid-count restarts the count
    apb_wr(2, 5);
    @(negedge HCLK); src[2] = 1;
    repeat (2) @(negedge HCLK);
    apb_wr(2, 32'hF);
    wait_lvl(2, 1, 40, n); check("lat_after_fwrite", n, 16);
    // asynchronous reset mid-count
    @(negedge HCLK); src[3] = 1;
    repeat (6) @(negedge HCLK);
    #2 HRESETn = 0;
    #1 check("async_rst_irq", irq, 0);
    check("async_rst_prdata", bus.PRDATA, 0);
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1;
    wait_lvl(2, 1, 30, n); check("lat_after_rst", n, 3);
    // randomized traffic, checked every cycle by the model
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        @(negedge HCLK); #2 HRESETn = 0;
        @(negedge HCLK); HRESETn = 1;
      end
      case ($urandom_range(0, 9))
        0, 1: begin
          n = $urandom_range(0, 7);
          apb_wr(n, n == 2 ? ($urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 2)))
                           : $urandom);
        end
        2: apb_rd($urandom_range(0, 7), d);
        default:
          repeat ($urandom_range(1, 8)) begin
            @(negedge HCLK);
            src = src ^ ($urandom & $urandom & $urandom);
          end
      endcase
    end
    repeat (5) @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
